// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: serialises instruction-fetch and data requests
// onto a single downstream request/response bus, one transaction at a time.
// Data normally wins. A streak counter bounds how long a waiting fetch can be
// starved. Fetches killed by a branch flush are withdrawn or silently discarded.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int D_STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ready,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                if_stall,
    output logic                d_stall,
    output logic                busy
);

    localparam logic [3:0] STREAK_MAX = 4'(D_STREAK_MAX);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic                  owner_i_q, owner_i_d;   // 1 = fetch owns the bus
    logic                  discard_q, discard_d;   // in-flight fetch was flushed
    logic [3:0]            streak_q, streak_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [DATA_W/8-1:0]   bus_be_q, bus_be_d;
    logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;
    logic                  if_ack_q, if_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
    logic                  grant_i, grant_d;
    logic                  fetch_ok;
    logic                  kill;

    // A fetch flushed in the same cycle it is raised is not worth starting.
    assign fetch_ok = if_req & ~if_flush;

    // Next-state, grant and bus-output logic.
    always_comb begin
        state_d     = state_q;
        owner_i_d   = owner_i_q;
        discard_d   = discard_q;
        streak_d    = streak_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        kill        = 1'b0;

        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (d_req && !(fetch_ok && streak_q == STREAK_MAX)) begin
                    grant_d = 1'b1;
                end else if (fetch_ok) begin
                    grant_i = 1'b1;
                end
                if (grant_d) begin
                    owner_i_d   = 1'b0;
                    bus_we_d    = d_we;
                    bus_be_d    = d_be;
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                    bus_req_d   = 1'b1;
                    state_d     = REQ;
                end else if (grant_i) begin
                    owner_i_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_req_d   = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus_ready) begin
                    // Accepted: a flush in the same cycle can no longer
                    // withdraw it, so the response must be swallowed.
                    bus_req_d = 1'b0;
                    state_d   = WAIT;
                    if (owner_i_q && if_flush) begin
                        discard_d = 1'b1;
                    end
                end else if (owner_i_q && if_flush) begin
                    bus_req_d = 1'b0;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WAIT: begin
                kill      = discard_q | (owner_i_q & if_flush);
                discard_d = kill;
                if (bus_rvalid) begin
                    state_d = RESP;
                    if (!kill) begin
                        if (owner_i_q) begin
                            if_rdata_d = bus_rdata;
                            if_ack_d   = 1'b1;
                        end else begin
                            d_rdata_d = bus_rdata;
                            d_ack_d   = 1'b1;
                        end
                    end
                end
            end
            RESP: begin
                discard_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!if_req || grant_i) begin
            streak_d = '0;
        end else if (grant_d && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_i_q   <= 1'b0;
            discard_q   <= 1'b0;
            streak_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_i_q   <= owner_i_d;
            discard_q   <= discard_d;
            streak_q    <= streak_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign d_stall   = d_req & ~d_ack_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a transaction-phase
// model of the arbiter.
module tb_mem_bus_arbiter;

    localparam int STREAK = 4;

    logic        clk;
    logic        rst;
    logic        if_req, if_flush, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        bus_req, bus_we, bus_ready, bus_rvalid;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        if_stall, d_stall, busy;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .D_STREAK_MAX(STREAK)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .if_stall(if_stall), .d_stall(d_stall), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one transaction record and its progress flags.
    bit          m_active, m_owner_i, m_accepted, m_have_resp, m_killed;
    int          m_streak;
    logic        e_if_ack, e_d_ack, e_bus_req, e_bus_we;
    logic [3:0]  e_bus_be;
    logic [31:0] e_bus_addr, e_bus_wdata, e_if_rdata, e_d_rdata;

    bit prev_if_ack, prev_d_ack, prev_flush, acc_last, pend;
    int pend_dly;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_owner_i = 0; m_accepted = 0; m_have_resp = 0; m_killed = 0;
        m_streak = 0;
        e_if_ack = 0; e_d_ack = 0; e_bus_req = 0; e_bus_we = 0; e_bus_be = 4'h0;
        e_bus_addr = 32'h0; e_bus_wdata = 32'h0; e_if_rdata = 32'h0; e_d_rdata = 32'h0;
    endtask

    // Advance the model by one clock using the inputs present this cycle.
    task automatic model_step();
        bit gi, gd, want_i;
        gi = 0; gd = 0;
        if (rst) begin
            model_reset();
        end else begin
            e_if_ack = 0;
            e_d_ack  = 0;
            if (!m_active) begin
                want_i = if_req && !if_flush;
                if (d_req && want_i) begin
                    if (m_streak == STREAK) gi = 1; else gd = 1;
                end else if (d_req) gd = 1;
                else if (want_i) gi = 1;
                if (gi || gd) begin
                    m_active = 1; m_owner_i = gi; m_accepted = 0;
                    m_have_resp = 0; m_killed = 0;
                    e_bus_req   = 1;
                    e_bus_we    = gd ? d_we : 1'b0;
                    e_bus_be    = gd ? d_be : 4'hF;
                    e_bus_addr  = gd ? d_addr : if_addr;
                    e_bus_wdata = gd ? d_wdata : 32'h0;
                end
            end else if (!m_accepted) begin
                if (bus_ready) begin
                    m_accepted = 1; e_bus_req = 0;
                    if (m_owner_i && if_flush) m_killed = 1;
                end else if (m_owner_i && if_flush) begin
                    m_active = 0; e_bus_req = 0;
                end
            end else if (!m_have_resp) begin
                if (m_owner_i && if_flush) m_killed = 1;
                if (bus_rvalid) begin
                    m_have_resp = 1;
                    if (!m_killed) begin
                        if (m_owner_i) begin e_if_ack = 1; e_if_rdata = bus_rdata; end
                        else begin e_d_ack = 1; e_d_rdata = bus_rdata; end
                    end
                end
            end else begin
                m_active = 0;
            end
            if (!if_req || gi) m_streak = 0;
            else if (gd && m_streak < STREAK) m_streak++;
        end
    endtask

    task automatic compare();
        chk1("if_ack", if_ack, e_if_ack);
        chk1("d_ack", d_ack, e_d_ack);
        chk1("bus_req", bus_req, e_bus_req);
        chk1("bus_we", bus_we, e_bus_we);
        chk1("busy", busy, m_active);
        chk1("if_stall", if_stall, if_req & ~e_if_ack);
        chk1("d_stall", d_stall, d_req & ~e_d_ack);
        chk32("bus_be", {28'd0, bus_be}, {28'd0, e_bus_be});
        chk32("bus_addr", bus_addr, e_bus_addr);
        chk32("bus_wdata", bus_wdata, e_bus_wdata);
        chk32("if_rdata", if_rdata, e_if_rdata);
        chk32("d_rdata", d_rdata, e_d_rdata);
    endtask

    // Inputs for this cycle are already applied; check, step model, advance.
    task automatic tick();
        #1;
        compare();
        prev_if_ack = e_if_ack;
        prev_d_ack  = e_d_ack;
        acc_last    = e_bus_req && bus_ready && !rst;
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Accept in the current REQ cycle, respond the next cycle; ends in RESP.
    task automatic serve(input logic [31:0] rd);
        bus_ready = 1; tick();
        bus_ready = 0; bus_rvalid = 1; bus_rdata = rd; tick();
        bus_rvalid = 0;
    endtask

    task automatic drive_random();
        if_flush = 0;
        if (if_req && (prev_if_ack || prev_flush)) if_req = 0;
        else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = $urandom;
        end
        if ($urandom_range(0, 24) == 0) if_flush = 1;
        prev_flush = if_flush;

        if (d_req && prev_d_ack) begin
            d_req = ($urandom_range(0, 1) == 1);
            d_we = ($urandom_range(0, 1) == 1); d_be = 4'($urandom);
            d_addr = $urandom; d_wdata = $urandom;
        end else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1;
            d_we = ($urandom_range(0, 1) == 1); d_be = 4'($urandom);
            d_addr = $urandom; d_wdata = $urandom;
        end

        bus_ready = ($urandom_range(0, 2) != 0);
        bus_rdata = $urandom;
        if (acc_last) begin pend = 1; pend_dly = int'($urandom_range(0, 3)); end
        bus_rvalid = 0;
        if (pend) begin
            if (pend_dly == 0) begin bus_rvalid = 1; pend = 0; end
            else pend_dly--;
        end else if (!m_active && $urandom_range(0, 7) == 0) begin
            bus_rvalid = 1;
        end
        rst = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        rst = 1; if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        prev_if_ack = 0; prev_d_ack = 0; prev_flush = 0; acc_last = 0;
        pend = 0; pend_dly = 0;
        model_reset();
        @(posedge clk); #1;
        tick();
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_if_ack", if_ack, 1'b0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        rst = 0;

        // Lone fetch: ack in the 4th cycle counting the IDLE sample cycle.
        if_req = 1; if_addr = 32'h00400000; tick();
        chk1("t1_bus_req", bus_req, 1'b1);
        chk32("t1_bus_addr", bus_addr, 32'h00400000);
        chk32("t1_bus_be", {28'd0, bus_be}, 32'h0000000F);
        serve(32'h24080005);
        chk1("t1_if_ack", if_ack, 1'b1);
        chk32("t1_if_rdata", if_rdata, 32'h24080005);
        chk1("t1_if_stall", if_stall, 1'b0);
        tick();
        if_req = 0;
        chk1("t1_ack_pulse", if_ack, 1'b0);
        tick();

        // Simultaneous fetch and store: data first, then fetch.
        if_req = 1; if_addr = 32'h00400100;
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h10010000; d_wdata = 32'hDEADBEEF;
        tick();
        chk1("t2_bus_we", bus_we, 1'b1);
        chk32("t2_bus_addr", bus_addr, 32'h10010000);
        chk32("t2_bus_wdata", bus_wdata, 32'hDEADBEEF);
        serve(32'h0);
        chk1("t2_d_ack", d_ack, 1'b1);
        tick();
        d_req = 0; d_we = 0;
        tick();
        chk32("t2_i_addr", bus_addr, 32'h00400100);
        chk1("t2_i_we", bus_we, 1'b0);
        serve(32'h00000013);
        chk1("t2_if_ack", if_ack, 1'b1);
        tick();
        if_req = 0;
        tick();

        // Continuous data traffic with a waiting fetch: 4 data grants, then fetch.
        if_req = 1; if_addr = 32'h00400200; d_req = 1; d_we = 0; d_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            d_addr = 32'h10010000 + 32'(k * 4);
            tick();
            chk32("t3_d_grant", bus_addr, d_addr);
            serve(32'(k));
            chk1("t3_d_ack", d_ack, 1'b1);
            tick();
        end
        d_addr = 32'h10010010;
        tick();
        chk32("t3_i_forced", bus_addr, 32'h00400200);
        chk1("t3_i_we", bus_we, 1'b0);
        serve(32'h0F0F0F0F);
        chk1("t3_if_ack", if_ack, 1'b1);
        tick();
        if_addr = 32'h00400204;
        tick();
        chk32("t3_streak_cleared", bus_addr, 32'h10010010);
        serve(32'h5);
        chk1("t3_d_ack2", d_ack, 1'b1);
        tick();
        d_req = 0; if_req = 0;
        tick();

        // Flush before acceptance withdraws the request.
        if_req = 1; if_addr = 32'h00400300; tick();
        if_flush = 1; bus_ready = 0; tick();
        chk1("t4_bus_req_drop", bus_req, 1'b0);
        chk1("t4_idle", busy, 1'b0);
        if_flush = 0; if_req = 0; tick();
        // Flush while waiting: response consumed, no ack, data unchanged.
        if_req = 1; if_addr = 32'h00400400; tick();
        bus_ready = 1; tick();
        bus_ready = 0; if_flush = 1; tick();
        if_flush = 0; if_req = 0; bus_rvalid = 1; bus_rdata = 32'h11111111; tick();
        bus_rvalid = 0;
        chk1("t4_no_ack", if_ack, 1'b0);
        chk32("t4_rdata_kept", if_rdata, 32'h0F0F0F0F);
        tick();
        chk1("t4_back_idle", busy, 1'b0);

        // Reset during WAIT; late response is ignored.
        d_req = 1; d_we = 0; d_addr = 32'h10010020; tick();
        bus_ready = 1; tick();
        bus_ready = 0; rst = 1; tick();
        rst = 0; d_req = 0; bus_rvalid = 1; bus_rdata = 32'h22222222; tick();
        bus_rvalid = 0;
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_d_ack", d_ack, 1'b0);
        chk32("t5_d_rdata", d_rdata, 32'h0);
        chk32("t5_bus_addr", bus_addr, 32'h0);

        // Ready withheld: request fields stay stable, requester stalls.
        d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h10010040; d_wdata = 32'hCAFEF00D;
        tick();
        for (int k = 0; k < 5; k++) begin
            bus_ready = 0; tick();
            chk1("t6_bus_req", bus_req, 1'b1);
            chk32("t6_bus_addr", bus_addr, 32'h10010040);
            chk32("t6_bus_wdata", bus_wdata, 32'hCAFEF00D);
            chk1("t6_bus_we", bus_we, 1'b1);
            chk1("t6_d_stall", d_stall, 1'b1);
        end
        serve(32'h0);
        chk1("t6_d_ack", d_ack, 1'b1);
        tick();
        d_req = 0; d_we = 0;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
